// File: rtl/game_pkg.sv
// Shared game-pipeline constants and the collision event FSM state type.
package game_pkg;

  localparam int unsigned H_RES        = 640;
  localparam int unsigned V_RES        = 480;
  localparam int unsigned SCREEN_CORDW = 16;
  localparam int unsigned COLR_BITS    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } evt_state_t;

endpackage

// File: rtl/collision_unit_if.sv
// Player-collision event handshake between the collision unit and its consumer.
interface collision_unit_if;

  logic evt_valid;
  logic evt_ready;
  logic evt_overflow;

  modport master (output evt_valid, output evt_overflow, input evt_ready);
  modport slave  (input evt_valid, input evt_overflow, output evt_ready);

endinterface

// File: rtl/collision_unit_popcount_sat.sv
// Adds PTS_PER_HIT per set bit of vec to score_in, clamping at the all-ones score.
module popcount_sat #(
  parameter int unsigned N           = 10,
  parameter int unsigned SCORE_W     = 10,
  parameter int unsigned PTS_PER_HIT = 1
) (
  input  logic [N-1:0]       vec,
  input  logic [SCORE_W-1:0] score_in,
  output logic [SCORE_W-1:0] score_next
);

  localparam int unsigned SUM_W = SCORE_W + 1;

  logic [SUM_W-1:0] cnt;
  logic [SUM_W-1:0] sum;

  // One guard bit above the score is enough to detect overflow of the add.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < int'(N); i++) begin
      cnt = cnt + SUM_W'(vec[i]);
    end
    sum        = SUM_W'(score_in) + cnt * SUM_W'(PTS_PER_HIT);
    score_next = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  end

endmodule

// File: rtl/collision_unit.sv
// Per-frame collision detector: accumulates shot/target/ship overlaps over the
// visible region, latches hit vectors at each frame strobe, scores and raises events.
module collision_unit
  import game_pkg::*;
#(
  parameter int unsigned N_TARGETS   = 10,
  parameter int unsigned N_SHOTS     = 4,
  parameter int unsigned SCORE_W     = 10,
  parameter int unsigned PTS_PER_HIT = 1
) (
  input  logic                 clk_pix,
  input  logic                 rst,
  input  logic                 frame,
  input  logic                 de,
  input  logic                 en,
  input  logic                 player_drawing,
  input  logic [N_SHOTS-1:0]   shot_drawing,
  input  logic [N_TARGETS-1:0] target_drawing,
  output logic [N_TARGETS-1:0] target_hit,
  output logic [N_SHOTS-1:0]   shot_consumed,
  output logic                 player_hit,
  output logic [SCORE_W-1:0]   score,
  collision_unit_if.master     evt
);

  logic [N_TARGETS-1:0] tgt_acc;
  logic [N_SHOTS-1:0]   shot_acc;
  logic                 ply_acc;
  logic                 frame_d;
  logic [SCORE_W-1:0]   score_next;
  logic                 any_shot;
  logic                 any_tgt;
  logic                 new_evt;
  evt_state_t           state;

  assign any_shot = |shot_drawing;
  assign any_tgt  = |target_drawing;
  assign new_evt  = frame & ply_acc;

  popcount_sat #(
    .N           (N_TARGETS),
    .SCORE_W     (SCORE_W),
    .PTS_PER_HIT (PTS_PER_HIT)
  ) u_score (
    .vec        (target_hit),
    .score_in   (score),
    .score_next (score_next)
  );

  // Accumulate during visible pixels, latch and clear on the frame strobe.
  // Score lags the latch by one cycle so it sums the already-registered hits.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      tgt_acc       <= '0;
      shot_acc      <= '0;
      ply_acc       <= 1'b0;
      target_hit    <= '0;
      shot_consumed <= '0;
      player_hit    <= 1'b0;
      frame_d       <= 1'b0;
      score         <= '0;
    end else begin
      frame_d <= frame;
      if (frame) begin
        target_hit    <= tgt_acc;
        shot_consumed <= shot_acc;
        player_hit    <= ply_acc;
        tgt_acc       <= '0;
        shot_acc      <= '0;
        ply_acc       <= 1'b0;
      end else if (de && en) begin
        tgt_acc  <= tgt_acc  | (target_drawing & {N_TARGETS{any_shot}});
        shot_acc <= shot_acc | (shot_drawing & {N_SHOTS{any_tgt}});
        ply_acc  <= ply_acc  | (player_drawing & any_tgt);
      end
      if (frame_d) begin
        score <= score_next;
      end
    end
  end

  // Event FSM: a pending event is only retired by evt_ready; a fresh collision
  // arriving unacknowledged marks overflow, which is sticky until reset.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      evt.evt_valid    <= 1'b0;
      evt.evt_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (new_evt) begin
            state         <= PEND;
            evt.evt_valid <= 1'b1;
          end
        end
        PEND: begin
          if (new_evt) begin
            if (!evt.evt_ready) begin
              evt.evt_overflow <= 1'b1;
            end
          end else if (evt.evt_ready) begin
            state         <= IDLE;
            evt.evt_valid <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          evt.evt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_unit.sv
// Bench for collision_unit: directed scenarios plus randomized frames, with two
// DUTs (10-bit and 4-bit score) checked every cycle against a frame-level model.
module tb_collision_unit;

  localparam int unsigned NT  = 10;
  localparam int unsigned NS  = 4;
  localparam int unsigned PTS = 1;

  logic          clk_pix = 1'b0;
  logic          rst = 1'b1;
  logic          frame = 1'b0;
  logic          de = 1'b0;
  logic          en = 1'b0;
  logic          player_drawing = 1'b0;
  logic [NS-1:0] shot_drawing = '0;
  logic [NT-1:0] target_drawing = '0;
  logic          rdy = 1'b0;

  logic [NT-1:0] th, th_s;
  logic [NS-1:0] sc, sc_s;
  logic          ph, ph_s;
  logic [9:0]    score;
  logic [3:0]    score_s;

  int n_checks = 0;
  int n_err = 0;

  collision_unit_if ifc ();
  collision_unit_if ifc_s ();
  assign ifc.evt_ready   = rdy;
  assign ifc_s.evt_ready = rdy;

  collision_unit #(.N_TARGETS(NT), .N_SHOTS(NS), .SCORE_W(10), .PTS_PER_HIT(PTS)) dut (
    .clk_pix(clk_pix), .rst(rst), .frame(frame), .de(de), .en(en),
    .player_drawing(player_drawing), .shot_drawing(shot_drawing),
    .target_drawing(target_drawing), .target_hit(th), .shot_consumed(sc),
    .player_hit(ph), .score(score), .evt(ifc.master)
  );

  collision_unit #(.N_TARGETS(NT), .N_SHOTS(NS), .SCORE_W(4), .PTS_PER_HIT(PTS)) dut_s (
    .clk_pix(clk_pix), .rst(rst), .frame(frame), .de(de), .en(en),
    .player_drawing(player_drawing), .shot_drawing(shot_drawing),
    .target_drawing(target_drawing), .target_hit(th_s), .shot_consumed(sc_s),
    .player_hit(ph_s), .score(score_s), .evt(ifc_s.master)
  );

  always #5 clk_pix = ~clk_pix;

  // Frame-level model: which objects were involved in any overlap this frame.
  bit [NT-1:0] m_acc_t = '0, m_th = '0;
  bit [NS-1:0] m_acc_s = '0, m_sc = '0;
  bit          m_acc_p = 1'b0, m_ph = 1'b0, m_latd = 1'b0, m_valid = 1'b0, m_ovf = 1'b0;
  int          m_score = 0, m_score_s = 0;

  function automatic int sat_add(input int a, input int b, input int maxv);
    return (a + b > maxv) ? maxv : a + b;
  endfunction

  task automatic model_step();
    int inc;
    if (rst) begin
      m_acc_t = '0; m_th = '0; m_acc_s = '0; m_sc = '0;
      m_acc_p = 0; m_ph = 0; m_latd = 0; m_valid = 0; m_ovf = 0;
      m_score = 0; m_score_s = 0;
      return;
    end
    if (m_latd) begin
      inc       = int'(PTS) * $countones(m_th);
      m_score   = sat_add(m_score, inc, 1023);
      m_score_s = sat_add(m_score_s, inc, 15);
    end
    m_latd = frame;
    if (frame) begin
      if (m_acc_p) begin
        if (m_valid && !rdy) m_ovf = 1'b1;
        m_valid = 1'b1;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
      m_th = m_acc_t; m_sc = m_acc_s; m_ph = m_acc_p;
      m_acc_t = '0; m_acc_s = '0; m_acc_p = 1'b0;
    end else begin
      if (m_valid && rdy) m_valid = 1'b0;
      if (de && en) begin
        for (int i = 0; i < int'(NT); i++)
          if (target_drawing[i] && shot_drawing != '0) m_acc_t[i] = 1'b1;
        for (int j = 0; j < int'(NS); j++)
          if (shot_drawing[j] && target_drawing != '0) m_acc_s[j] = 1'b1;
        if (player_drawing && target_drawing != '0) m_acc_p = 1'b1;
      end
    end
  endtask

  always @(posedge clk_pix or posedge rst) model_step();

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk_pix) begin
    check("target_hit",    32'(th),     32'(m_th));
    check("shot_consumed", 32'(sc),     32'(m_sc));
    check("player_hit",    32'(ph),     32'(m_ph));
    check("score",         32'(score),  32'(m_score));
    check("evt_valid",     32'(ifc.evt_valid),    32'(m_valid));
    check("evt_overflow",  32'(ifc.evt_overflow), 32'(m_ovf));
    check("target_hit_s",  32'(th_s),   32'(m_th));
    check("shot_consumed_s", 32'(sc_s), 32'(m_sc));
    check("player_hit_s",  32'(ph_s),   32'(m_ph));
    check("score_s",       32'(score_s), 32'(m_score_s));
    check("evt_valid_s",   32'(ifc_s.evt_valid),    32'(m_valid));
    check("evt_overflow_s", 32'(ifc_s.evt_overflow), 32'(m_ovf));
  end

  // Inputs change 1 time unit after the edge and are consumed at the next edge.
  task automatic drive(input logic fr, input logic d, input logic e, input logic pl,
                       input logic [NS-1:0] sh, input logic [NT-1:0] tg, input logic r);
    @(posedge clk_pix);
    #1;
    frame = fr; de = d; en = e; player_drawing = pl;
    shot_drawing = sh; target_drawing = tg; rdy = r;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, '0, '0, rdy);
  endtask

  task automatic sync_reset();
    drive(0, 0, 0, 0, '0, '0, 0);
    rst = 1'b1;
    drive(0, 0, 0, 0, '0, '0, 0);
    rst = 1'b0;
  endtask

  task automatic hit_frame(input logic [NS-1:0] sh, input logic [NT-1:0] tg);
    drive(0, 1, 1, 0, sh, tg, 0);
    drive(1, 1, 1, 0, '0, '0, 0);
  endtask

  initial begin
    int len, mode, drop;
    logic e;

    repeat (2) @(posedge clk_pix);
    #1 rst = 1'b0;
    check("rst_target_hit", 32'(th), 32'h0);
    check("rst_score", 32'(score), 32'h0);
    check("rst_evt_valid", 32'(ifc.evt_valid), 32'h0);
    check("rst_evt_overflow", 32'(ifc.evt_overflow), 32'h0);

    // Single overlap: shot 1 on target 3 for five visible cycles.
    for (int k = 0; k < 5; k++) drive(0, 1, 1, 0, 4'b0010, 10'h008, 0);
    drive(1, 0, 0, 0, '0, '0, 0);
    drive(0, 0, 0, 0, '0, '0, 0);
    check("single_th", 32'(th), 32'h008);
    check("single_sc", 32'(sc), 32'h2);
    check("single_ph", 32'(ph), 32'h0);
    check("single_score_early", 32'(score), 32'h0);
    drive(0, 0, 0, 0, '0, '0, 0);
    check("single_score", 32'(score), 32'd1);
    check("single_evt", 32'(ifc.evt_valid), 32'h0);

    // Multi-hit with two shots on one target, one shot on two targets.
    drive(0, 1, 1, 0, 4'b0101, 10'h020, 0);
    drive(0, 1, 1, 0, 4'b0010, 10'h280, 0);
    drive(1, 0, 0, 0, '0, '0, 0);
    drive(0, 0, 0, 0, '0, '0, 0);
    check("multi_th", 32'(th), 32'h2A0);
    check("multi_sc", 32'(sc), 32'h7);
    drive(0, 0, 0, 0, '0, '0, 0);
    check("multi_score", 32'(score), 32'd4);

    // Blanking and disable: overlaps ignored, then en drop after a real hit.
    drive(0, 0, 1, 1, 4'b1111, 10'h3FF, 0);
    drive(0, 1, 0, 1, 4'b1111, 10'h3FF, 0);
    drive(1, 0, 0, 0, '0, '0, 0);
    idle(2);
    check("blank_th", 32'(th), 32'h0);
    check("blank_score", 32'(score), 32'd4);
    drive(0, 1, 1, 0, 4'b0001, 10'h001, 0);
    drive(0, 1, 0, 0, 4'b0001, 10'h002, 0);
    drive(1, 0, 0, 0, '0, '0, 0);
    idle(2);
    check("en_drop_th", 32'(th), 32'h001);
    check("en_drop_score", 32'(score), 32'd5);

    // Saturation on the 4-bit score.
    sync_reset();
    for (int k = 0; k < 14; k++) hit_frame(4'b0001, 10'h001);
    idle(2);
    check("sat_pre", 32'(score_s), 32'd14);
    hit_frame(4'b0001, 10'h007);
    idle(2);
    check("sat_clamp", 32'(score_s), 32'd15);
    check("sat_wide", 32'(score), 32'd17);
    hit_frame(4'b0001, 10'h001);
    idle(2);
    check("sat_hold", 32'(score_s), 32'd15);

    // Event handshake: overflow, accept racing a new event, then plain accept.
    drive(0, 1, 1, 1, '0, 10'h010, 0);
    drive(1, 0, 0, 0, '0, '0, 0);
    drive(0, 0, 0, 0, '0, '0, 0);
    check("evtA_valid", 32'(ifc.evt_valid), 32'h1);
    check("evtA_ovf", 32'(ifc.evt_overflow), 32'h0);
    check("evtA_ph", 32'(ph), 32'h1);
    drive(0, 1, 1, 1, '0, 10'h010, 0);
    drive(1, 0, 0, 0, '0, '0, 0);
    drive(0, 0, 0, 0, '0, '0, 0);
    check("evtB_valid", 32'(ifc.evt_valid), 32'h1);
    check("evtB_ovf", 32'(ifc.evt_overflow), 32'h1);
    drive(0, 1, 1, 1, '0, 10'h010, 0);
    drive(1, 0, 0, 0, '0, '0, 1);
    drive(0, 0, 0, 0, '0, '0, 0);
    check("race_valid", 32'(ifc.evt_valid), 32'h1);
    drive(0, 0, 0, 0, '0, '0, 1);
    drive(0, 0, 0, 0, '0, '0, 0);
    check("accept_valid", 32'(ifc.evt_valid), 32'h0);
    check("accept_ovf", 32'(ifc.evt_overflow), 32'h1);

    // Async reset between edges after accumulating hits.
    drive(0, 1, 1, 1, 4'b0001, 10'h001, 0);
    #3 rst = 1'b1;
    #1;
    check("arst_ph", 32'(ph), 32'h0);
    check("arst_score", 32'(score), 32'h0);
    check("arst_valid", 32'(ifc.evt_valid), 32'h0);
    check("arst_ovf", 32'(ifc.evt_overflow), 32'h0);
    drive(0, 0, 0, 0, '0, '0, 0);
    rst = 1'b0;
    drive(0, 1, 1, 0, 4'b1000, 10'h200, 0);
    drive(1, 0, 0, 0, '0, '0, 0);
    drive(0, 0, 0, 0, '0, '0, 0);
    check("post_rst_th", 32'(th), 32'h200);
    check("post_rst_sc", 32'(sc), 32'h8);

    // Randomized frames; the per-cycle compare checks everything.
    for (int f = 0; f < 300; f++) begin
      len  = $urandom_range(2, 15);
      mode = $urandom_range(0, 3);
      drop = $urandom_range(1, len);
      for (int c = 0; c < len; c++) begin
        e = (mode == 0) ? 1'b0 : (mode == 1) ? (c < drop) : 1'b1;
        drive(0, $urandom_range(0, 4) != 0, e, $urandom_range(0, 3) == 0,
              NS'($urandom) & NS'($urandom),
              NT'($urandom) & NT'($urandom) & NT'($urandom),
              $urandom_range(0, 2) == 0);
        if ($urandom_range(0, 199) == 0) begin
          #2 rst = 1'b1;
          @(posedge clk_pix);
          #1 rst = 1'b0;
        end
      end
      drive(1, 1, 1, 1, NS'($urandom), NT'($urandom), $urandom_range(0, 1) == 0);
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/collision_unit.md
Name: collision_unit

Overview:
Parametrised per-frame collision detector for the game pipeline. It generalises the single-bullet/asteroid check to N_SHOTS projectiles against N_TARGETS targets plus the player ship. It accumulates pixel overlaps during the visible region and latches per-object hit vectors at each frame strobe. It keeps a saturating score counter and exposes player-collision events over a valid/ready handshake.

Parameters:
N_TARGETS, 10, number of target (asteroid) channels
N_SHOTS, 4, number of projectile channels
SCORE_W, 10, width of saturating score counter
PTS_PER_HIT, 1, score increment per target hit

Ports:
clk_pix  in  1  pixel clock, 25 MHz
rst  in  1  asynchronous active-high reset
frame  in  1  one-cycle strobe at start of each frame
de  in  1  visible-region qualifier
en  in  1  collision detection enable
player_drawing  in  1  ship sprite covers current pixel
shot_drawing  in  N_SHOTS  per-projectile coverage of current pixel
target_drawing  in  N_TARGETS  per-target coverage of current pixel
target_hit  out  N_TARGETS  targets hit in previous frame, held for one frame
shot_consumed  out  N_SHOTS  projectiles that struck any target in previous frame
player_hit  out  1  ship overlapped any target in previous frame
score  out  SCORE_W  saturating cumulative target-hit score
evt_valid  out  1  pending player-collision event
evt_ready  in  1  consumer accepts event
evt_overflow  out  1  sticky: event arrived while one was pending

Behaviour:
- Reset (async assert, sync release): all accumulators, outputs, score, evt_valid and evt_overflow = 0.
- Accumulation happens on cycles with frame=0, de=1, en=1:
  - tgt_acc[i] |= target_drawing[i] & (|shot_drawing)
  - shot_acc[j] |= shot_drawing[j] & (|target_drawing)
  - ply_acc |= player_drawing & (|target_drawing)
- Cycles with de=0 or en=0 do not change the accumulators. The frame cycle itself is never accumulated.
- On a frame cycle:
  - target_hit <= tgt_acc, shot_consumed <= shot_acc, player_hit <= ply_acc, all registered.
  - Accumulators clear to 0 in the same cycle.
  - Latency: outputs change exactly 1 cycle after frame=1 and hold until the next frame.
- Score:
  - On the cycle after a frame latch, score += PTS_PER_HIT * popcount(target_hit). This is one extra cycle of pipeline, so score changes 2 cycles after frame.
  - Score saturates at 2^SCORE_W-1 and never wraps. The popcount sum is computed at SCORE_W+1 bits before the compare.
- Event FSM, states IDLE and PEND:
  - IDLE -> PEND when a frame latch has ply_acc=1; evt_valid=1 in PEND.
  - PEND -> IDLE when evt_ready=1 and no new player collision latches on that cycle.
  - Acceptance and a new collision latch in the same cycle: stay in PEND (new event), evt_overflow unchanged.
  - New collision latch in PEND without ready: stay in PEND and set evt_overflow=1. It clears only on rst.
  - evt_valid never drops without evt_ready.
- Enable:
  - en=0 mid-frame freezes accumulation, but values already accumulated are still latched at the next frame.
  - en=0 for an entire frame yields all-zero outputs for the following frame.
- Channels are independent:
  - Two shots hitting the same target in one frame count once for that target.
  - One shot hitting two targets sets both target bits, i.e. score +2.
- Reset mid-frame discards accumulated state. The first post-reset frame strobe latches only pixels seen since reset.

Decomposition:
- Shared package game_pkg holds H_RES, V_RES, SCREEN_CORDW, COLR_BITS and the event-FSM enum type evt_state_t {IDLE, PEND}.
- One sub-module: popcount_sat, a combinational popcount of an N-bit vector scaled by PTS_PER_HIT and added to score with saturation. Parametrised by width N and SCORE_W.

Test Plan:
- Single overlap. Drive shot_drawing=4'b0010 and target_drawing[3]=1 together for 5 de cycles, then frame. Expect: 1 cycle later target_hit=10'h008 and shot_consumed=4'b0010; 2 cycles later score=1; player_hit=0, evt_valid=0.
- Multi-hit and same-target dedup. Shots 0 and 2 both overlap target 5; shot 1 overlaps targets 7 and 9. Expect target_hit=10'h2A0, shot_consumed=4'b0111, score +3.
- Blanking and disable. Overlaps only with de=0, or only with en=0. Expect all-zero outputs and no score change after the frame. Then overlaps with en=1 followed by en=0 before the frame: those hits are latched.
- Saturation. Use SCORE_W=4, preload score to 14 via 14 single-hit frames, then a 3-target frame. Expect score=15, held on further hits.
- Event handshake. Player collision in frame A with evt_ready=0, then again in frame B: expect evt_valid=1 and evt_overflow=1. Raise evt_ready in a cycle where a frame latch also carries ply_acc=1: evt_valid stays 1. Raise evt_ready alone: evt_valid=0 the next cycle.
- Async reset mid-frame. Assert rst asynchronously between clock edges after accumulating hits: outputs, score, evt_valid and evt_overflow go to 0 immediately. The next frame latches only post-reset overlaps.
